// File: rtl/uart_rx_ctrl_if.sv
// Read-side FIFO bus of the UART receive controller.
// The controller drives data, valid and occupancy, and the consumer drives rd_ack.
interface uart_rx_ctrl_if #(
    parameter int unsigned AW = 3
) ();
    logic          rd_valid;
    logic [7:0]    rd_data;
    logic          rd_ack;
    logic [AW:0]   count;

    // Controller side: produces bytes.
    modport master (
        output rd_valid,
        output rd_data,
        output count,
        input  rd_ack
    );

    // Consumer side: pops bytes.
    modport slave (
        input  rd_valid,
        input  rd_data,
        input  count,
        output rd_ack
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller.
// Holds uart_rx in reset after (re)start and captures each rising rx_ready into a
// show-ahead FIFO. Tracks FIFO overrun and pulses idle at the end of a receive burst.
module uart_rx_ctrl #(
    parameter int unsigned AW        = 3,
    parameter int unsigned HoldTicks = 16,
    parameter int unsigned IdleTicks = 80
) (
    input  logic                 ref_clk,
    input  logic                 reset,
    input  logic                 samp_clk,
    input  logic                 en,
    input  logic                 flush,
    input  logic                 clr_status,
    input  logic                 rx_ready,
    input  logic [7:0]           rx_data,
    output logic                 rx_reset,
    output logic                 overrun,
    output logic                 idle,
    uart_rx_ctrl_if.master       rd
);
    localparam int unsigned Depth = 1 << AW;
    localparam int unsigned HCW   = $clog2(HoldTicks + 1);
    localparam int unsigned ICW   = $clog2(IdleTicks + 1);
    localparam logic [AW:0] FullCnt = (AW+1)'(Depth);

    typedef enum logic [1:0] {StHold, StRun, StOff} state_e;

    state_e           state_q, state_d;
    logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
    logic             rx_reset_q, rx_reset_d;
    logic             rdy_q, rdy_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             overrun_q, overrun_d;
    logic [ICW-1:0]   idle_cnt_q, idle_cnt_d;
    logic             armed_q, armed_d;
    logic             idle_q, idle_d;
    logic [7:0]       mem_q [Depth];

    logic in_run, capture, pop, full, do_push, ovr_set, fire;

    // Start-up sequencing: hold uart_rx in reset for HoldTicks strobes, then run.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            StHold: begin
                if (samp_clk) begin
                    hold_cnt_d = hold_cnt_q + HCW'(1);
                    if (hold_cnt_q == HCW'(HoldTicks - 1)) begin
                        hold_cnt_d = '0;
                        state_d    = en ? StRun : StOff;
                    end
                end
            end
            StRun: begin
                if (!en) state_d = StOff;
            end
            StOff: begin
                hold_cnt_d = '0;
                if (en) state_d = StHold;
            end
            default: begin
                state_d    = StHold;
                hold_cnt_d = '0;
            end
        endcase
        // Registered from the next state so rx_reset lines up with state_q.
        rx_reset_d = (state_d != StRun);
    end

    // Capture detection and FIFO bookkeeping; flush wins over push and pop.
    always_comb begin
        in_run   = (state_q == StRun);
        rdy_d    = in_run ? rx_ready : 1'b0;
        capture  = in_run && rx_ready && !rdy_q;
        full     = (cnt_q == FullCnt);
        pop      = rd.rd_ack && (cnt_q != '0) && !flush;
        do_push  = capture && (!full || pop) && !flush;
        ovr_set  = capture && full && !pop && !flush;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
            else if (pop && !do_push) cnt_d = cnt_q - (AW+1)'(1);
        end

        overrun_d = overrun_q;
        if (ovr_set)         overrun_d = 1'b1;
        else if (clr_status) overrun_d = 1'b0;
    end

    // Idle detection: count quiet strobes after the last capture, fire once per burst.
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        armed_d    = armed_q;
        fire       = 1'b0;
        if (!in_run) begin
            idle_cnt_d = '0;
            armed_d    = 1'b0;
        end else if (capture) begin
            idle_cnt_d = '0;
            armed_d    = 1'b1;
        end else begin
            fire = armed_q && (idle_cnt_q == ICW'(IdleTicks));
            if (fire) armed_d = 1'b0;
            if (samp_clk && (idle_cnt_q != ICW'(IdleTicks))) idle_cnt_d = idle_cnt_q + ICW'(1);
        end
        idle_d = fire;
    end

    // State and control registers.
    always_ff @(posedge ref_clk) begin
        if (reset) begin
            state_q    <= StHold;
            hold_cnt_q <= '0;
            rx_reset_q <= 1'b1;
            rdy_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            overrun_q  <= 1'b0;
            idle_cnt_q <= '0;
            armed_q    <= 1'b0;
            idle_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            rx_reset_q <= rx_reset_d;
            rdy_q      <= rdy_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            overrun_q  <= overrun_d;
            idle_cnt_q <= idle_cnt_d;
            armed_q    <= armed_d;
            idle_q     <= idle_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge ref_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= rx_data;
    end

    assign rx_reset    = rx_reset_q;
    assign overrun     = overrun_q;
    assign idle        = idle_q;
    assign rd.rd_valid = (cnt_q != '0);
    assign rd.rd_data  = mem_q[rd_ptr_q];
    assign rd.count    = cnt_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed sequences, a vector table and a randomized
// run against a queue-based reference model.
module tb_uart_rx_ctrl;
    logic ref_clk = 1'b0;
    logic reset, samp_clk, en, flush, clr_status, rx_ready;
    logic [7:0] rx_data;
    logic rx_reset, overrun, idle;

    uart_rx_ctrl_if #(.AW(3)) rd_if ();

    uart_rx_ctrl #(.AW(3), .HoldTicks(16), .IdleTicks(80)) dut (
        .ref_clk    (ref_clk),
        .reset      (reset),
        .samp_clk   (samp_clk),
        .en         (en),
        .flush      (flush),
        .clr_status (clr_status),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .rx_reset   (rx_reset),
        .overrun    (overrun),
        .idle       (idle),
        .rd         (rd_if.master)
    );

    always #5 ref_clk = ~ref_clk;

    int total = 0;
    int bad = 0;
    int pulses = 0;

    always @(negedge ref_clk) if (idle === 1'b1) pulses++;

    typedef struct {
        logic       rdy;
        logic [7:0] data;
        logic       ack;
        logic       fl;
        logic       clr;
        int         cnt;
        logic       vld;
        logic [7:0] head;
        logic       ovr;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] mq[$];
    logic movr;

    function automatic vec_t mk(logic rdy, logic [7:0] data, logic ack, logic fl, logic clr,
                                int cnt, logic vld, logic [7:0] head, logic ovr);
        vec_t v;
        v.rdy = rdy; v.data = data; v.ack = ack; v.fl = fl; v.clr = clr;
        v.cnt = cnt; v.vld = vld; v.head = head; v.ovr = ovr;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ref_clk);
        #1;
    endtask

    task automatic strobe();
        samp_clk = 1'b1;
        step();
        samp_clk = 1'b0;
        step();
    endtask

    task automatic push_byte(logic [7:0] d);
        rx_data  = d;
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        step();
    endtask

    task automatic pop_byte();
        rd_if.rd_ack = 1'b1;
        step();
        rd_if.rd_ack = 1'b0;
    endtask

    task automatic chk_model(string tag);
        chk({tag, ".count"}, 32'(rd_if.count), 32'(mq.size()));
        chk({tag, ".valid"}, 32'(rd_if.rd_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk({tag, ".head"}, 32'(rd_if.rd_data), 32'(mq[0]));
        chk({tag, ".overrun"}, 32'(overrun), 32'(movr));
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; samp_clk = 1'b0; flush = 1'b0; clr_status = 1'b0;
        rx_ready = 1'b0; rx_data = 8'h00; rd_if.rd_ack = 1'b0;

        // Reset state, with activity on the inputs.
        rx_ready = 1'b1; samp_clk = 1'b1;
        step(); step();
        chk("rst.rx_reset", 32'(rx_reset), 1);
        chk("rst.valid", 32'(rd_if.rd_valid), 0);
        chk("rst.count", 32'(rd_if.count), 0);
        chk("rst.overrun", 32'(overrun), 0);
        chk("rst.idle", 32'(idle), 0);
        rx_ready = 1'b0; samp_clk = 1'b0;
        reset = 1'b0;
        step();

        // Hold phase: rx_reset drops the cycle after the 16th strobe.
        repeat (15) strobe();
        chk("hold15.rx_reset", 32'(rx_reset), 1);
        samp_clk = 1'b1;
        step();
        samp_clk = 1'b0;
        chk("hold16.rx_reset", 32'(rx_reset), 0);

        // Levels held high for 5 cycles give exactly one push each.
        begin
            logic [7:0] bytes3 [3];
            bytes3[0] = 8'hAC; bytes3[1] = 8'h93; bytes3[2] = 8'h4D;
            for (int i = 0; i < 3; i++) begin
                rx_data = bytes3[i];
                rx_ready = 1'b1;
                repeat (5) step();
                rx_ready = 1'b0;
                step();
            end
            chk("three.count", 32'(rd_if.count), 3);
            for (int i = 0; i < 3; i++) begin
                chk("three.head", 32'(rd_if.rd_data), 32'(bytes3[i]));
                pop_byte();
            end
            chk("three.count_end", 32'(rd_if.count), 0);
            chk("three.valid_end", 32'(rd_if.rd_valid), 0);
        end

        // Vector table, starting from an empty FIFO with overrun clear.
        vecs.push_back(mk(1, 8'h11, 0, 0, 0, 1, 1, 8'h11, 0));
        vecs.push_back(mk(1, 8'h22, 1, 0, 0, 1, 1, 8'h22, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0));
        for (int i = 0; i < 8; i++) vecs.push_back(mk(1, 8'(i), 0, 0, 0, i + 1, 1, 8'h00, 0));
        vecs.push_back(mk(1, 8'h12, 0, 0, 0, 8, 1, 8'h00, 1));
        vecs.push_back(mk(1, 8'h13, 0, 0, 1, 8, 1, 8'h00, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 8, 1, 8'h00, 0));
        vecs.push_back(mk(1, 8'hAA, 1, 0, 0, 8, 1, 8'h01, 0));
        for (int i = 0; i < 6; i++) vecs.push_back(mk(0, 8'h00, 1, 0, 0, 7 - i, 1, 8'(i + 2), 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 1, 8'hAA, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 8'h31, 0, 0, 0, 1, 1, 8'h31, 0));
        vecs.push_back(mk(1, 8'h32, 1, 1, 0, 0, 0, 8'h00, 0));
        foreach (vecs[k]) begin
            rx_ready = vecs[k].rdy; rx_data = vecs[k].data; rd_if.rd_ack = vecs[k].ack;
            flush = vecs[k].fl; clr_status = vecs[k].clr;
            step();
            rx_ready = 1'b0; rd_if.rd_ack = 1'b0; flush = 1'b0; clr_status = 1'b0;
            chk($sformatf("vec%0d.count", k), 32'(rd_if.count), 32'(vecs[k].cnt));
            chk($sformatf("vec%0d.valid", k), 32'(rd_if.rd_valid), 32'(vecs[k].vld));
            if (vecs[k].vld) chk($sformatf("vec%0d.head", k), 32'(rd_if.rd_data), 32'(vecs[k].head));
            chk($sformatf("vec%0d.overrun", k), 32'(overrun), 32'(vecs[k].ovr));
            step();
        end

        // Randomized traffic against the queue model.
        flush = 1'b1; clr_status = 1'b1;
        step();
        flush = 1'b0; clr_status = 1'b0;
        mq.delete();
        movr = 1'b0;
        for (int n = 0; n < 300; n++) begin
            logic p, a, f, c, popped, set;
            logic [7:0] d;
            p = ($urandom_range(0, 99) < 60);
            a = ($urandom_range(0, 99) < 40);
            f = ($urandom_range(0, 99) < 3);
            c = ($urandom_range(0, 99) < 10);
            d = 8'($urandom);
            rx_ready = p; rx_data = d; rd_if.rd_ack = a; flush = f; clr_status = c;
            step();
            rx_ready = 1'b0; rd_if.rd_ack = 1'b0; flush = 1'b0; clr_status = 1'b0;
            if (f) begin
                mq.delete();
                if (c) movr = 1'b0;
            end else begin
                popped = a && (mq.size() > 0);
                if (popped) void'(mq.pop_front());
                set = 1'b0;
                if (p) begin
                    if (mq.size() < 8) mq.push_back(d);
                    else set = 1'b1;
                end
                if (set) movr = 1'b1;
                else if (c) movr = 1'b0;
            end
            chk_model("rnd");
            step();
            chk_model("rnd_gap");
        end

        // Idle pulse: one per burst, none while disarmed.
        flush = 1'b1; clr_status = 1'b1;
        step();
        flush = 1'b0; clr_status = 1'b0;
        begin
            int p0;
            push_byte(8'h5A);
            p0 = pulses;
            repeat (79) strobe();
            chk("idle79.pulses", 32'(pulses - p0), 0);
            strobe();
            repeat (3) step();
            chk("idle80.pulses", 32'(pulses - p0), 1);
            repeat (200) strobe();
            chk("idle280.pulses", 32'(pulses - p0), 1);
            push_byte(8'h55);
            repeat (80) strobe();
            repeat (3) step();
            chk("idle_again.pulses", 32'(pulses - p0), 2);
        end

        // Disable keeps the FIFO, flush empties it, re-enable repeats the hold.
        flush = 1'b1;
        step();
        flush = 1'b0;
        push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
        en = 1'b0;
        step();
        chk("off.rx_reset", 32'(rx_reset), 1);
        chk("off.count", 32'(rd_if.count), 3);
        step();
        chk("off.count2", 32'(rd_if.count), 3);
        chk("off.head", 32'(rd_if.rd_data), 8'h01);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("off_flush.count", 32'(rd_if.count), 0);
        chk("off_flush.valid", 32'(rd_if.rd_valid), 0);
        en = 1'b1;
        step();
        repeat (15) strobe();
        chk("rehold15.rx_reset", 32'(rx_reset), 1);
        samp_clk = 1'b1;
        step();
        samp_clk = 1'b0;
        chk("rehold16.rx_reset", 32'(rx_reset), 0);

        // Reset overrides a same-cycle capture and pop.
        push_byte(8'h21); push_byte(8'h22);
        chk("prerst.count", 32'(rd_if.count), 2);
        reset = 1'b1; rx_ready = 1'b1; rx_data = 8'h77; rd_if.rd_ack = 1'b1;
        step();
        reset = 1'b0; rx_ready = 1'b0; rd_if.rd_ack = 1'b0;
        chk("midrst.count", 32'(rd_if.count), 0);
        chk("midrst.valid", 32'(rd_if.rd_valid), 0);
        chk("midrst.rx_reset", 32'(rx_reset), 1);
        chk("midrst.overrun", 32'(overrun), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter AW, default 3, meaning log2 of the receive FIFO depth (8 entries).
REQ-002 SHALL have parameter HoldTicks, default 16, meaning the number of samp_clk strobes rx_reset is held after (re)start.
REQ-003 SHALL have parameter IdleTicks, default 80, meaning the number of samp_clk strobes without a new byte before idle fires.
REQ-004 ref_clk  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 samp_clk  in  1  sample-rate enable strobe, one ref_clk wide, same strobe fed to uart_rx.
REQ-007 en  in  1  receiver enable.
REQ-008 flush  in  1  one-cycle pulse; empties the FIFO.
REQ-009 clr_status  in  1  one-cycle pulse; clears overrun.
REQ-010 rx_ready  in  1  ready level from uart_rx.
REQ-011 rx_data  in  8  out bus from uart_rx.
REQ-012 rx_reset  out  1  reset to uart_rx, registered.
REQ-013 rd_valid  out  1  FIFO non-empty.
REQ-014 rd_data  out  8  FIFO head byte, valid while rd_valid=1.
REQ-015 rd_ack  in  1  pop request; a pop occurs when rd_ack=1 and rd_valid=1.
REQ-016 count  out  AW+1  FIFO occupancy, 0..2^AW.
REQ-017 overrun  out  1  sticky flag: a byte was dropped because the FIFO was full.
REQ-018 idle  out  1  one-cycle pulse marking the end of a receive burst.

Function
REQ-019 SHALL implement FSM states HOLD, RUN and OFF.
REQ-020 HOLD: rx_reset=1, count samp_clk strobes; after the HoldTicks-th strobe, go to RUN if en=1, else to OFF.
REQ-021 RUN: rx_reset=0; go to OFF on the cycle after en=0 is sampled.
REQ-022 OFF: rx_reset=1; go to HOLD with the hold counter cleared when en=1.
REQ-023 SHALL register rx_ready as rdy_q; rdy_q SHALL be forced to 0 outside RUN.
REQ-024 Capture: in RUN, when rx_ready=1 and rdy_q=0, push rx_data exactly once; a rx_ready level held high for N cycles SHALL produce one push.
REQ-025 FIFO: show-ahead; rd_data = head entry; rd_valid = (count!=0); a push into an empty FIFO SHALL give rd_valid=1 and rd_data=byte on the next cycle.
REQ-026 Order: bytes SHALL be read out in capture order; pointers are AW bits and wrap modulo 2^AW.
REQ-027 Capture when count=2^AW with no pop: the byte is dropped, overrun<=1, count and contents unchanged.
REQ-028 Capture and pop in the same cycle: pop then push; count unchanged, no overrun, valid also when full.
REQ-029 rd_ack when empty SHALL be ignored; count never underflows.
REQ-030 flush SHALL set count=0 and both pointers to 0; it takes priority over a same-cycle push and pop, and the pushed byte is discarded without setting overrun.
REQ-031 clr_status SHALL clear overrun; a same-cycle overrun event takes priority (overrun stays 1).
REQ-032 Idle counter: cleared on each capture; incremented on each samp_clk strobe in RUN; saturates at IdleTicks.
REQ-033 SHALL pulse idle for one ref_clk when the idle counter reaches IdleTicks and the armed flag is set; a capture sets armed and the idle pulse clears it.
REQ-034 Leaving RUN SHALL clear armed and the idle counter; FIFO contents and overrun SHALL be retained.

Reset
REQ-035 On reset=1: state=HOLD, hold counter=0, rx_reset=1, rdy_q=0, count=0, pointers=0, rd_valid=0, overrun=0, idle=0, armed=0, idle counter=0.
REQ-036 reset SHALL override all other inputs in the same cycle, including mid-capture and mid-pop; FIFO contents are discarded.

Verification
REQ-037 Reset, en=1 -> rx_reset=1, rd_valid=0, count=0; rx_reset falls the cycle after the 16th samp_clk strobe.
REQ-038 rx_ready pulses carrying 0xAC, 0x93, 0x4D, each held high 5 cycles -> count=3; reads return 0xAC, 0x93, 0x4D; count=0 after the third rd_ack.
REQ-039 Push 8 bytes 0x00..0x07, then 0x12 -> overrun=1, count=8, head=0x00; clr_status -> overrun=0.
REQ-040 Full FIFO, capture 0xAA with rd_ack in the same cycle -> count=8, overrun=0, eighth read returns 0xAA.
REQ-041 One capture then 80 strobes -> exactly one idle pulse; a further 200 strobes produce no pulse; 0x55 then 80 strobes -> one pulse.
REQ-042 3 bytes queued, en=0 -> rx_reset=1 next cycle, count stays 3; flush -> count=0, rd_valid=0; en=1 -> HOLD for 16 strobes, then RUN.
